// File: rtl/game_pkg.sv
// Shared types and constants for the game-progress controller and its peers.
package game_pkg;

    localparam int unsigned SCORE_W   = 4;
    localparam int unsigned LIVES_W   = 3;
    localparam int unsigned L1_TARGET = 4;
    localparam int unsigned L2_TARGET = 6;

    typedef logic [1:0] level_code_t;

    localparam level_code_t LEVEL_ONE = 2'b00;
    localparam level_code_t LEVEL_TWO = 2'b01;
    localparam level_code_t LEVEL_WON = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        CLEAR,
        WIN,
        LOSE
    } state_t;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    // Score increment that holds at the maximum instead of wrapping.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/level_progress_ctrl_if.sv
// Collision inputs and level/score/status outputs of the game-progress controller.
interface level_progress_ctrl_if import game_pkg::*; ();

    logic                startGame;
    logic                coinHit;
    logic                flagHit;
    logic                flagEnable;
    logic                playerHit;
    level_code_t         levelCode;
    logic [SCORE_W-1:0]  score;
    logic [LIVES_W-1:0]  lives;
    logic                levelStart;
    logic                gameWon;
    logic                gameOver;

    modport master (
        input  startGame, coinHit, flagHit, flagEnable, playerHit,
        output levelCode, score, lives, levelStart, gameWon, gameOver
    );

    modport slave (
        output startGame, coinHit, flagHit, flagEnable, playerHit,
        input  levelCode, score, lives, levelStart, gameWon, gameOver
    );

endinterface

// File: rtl/edge_detect.sv
// Single-bit rising-edge detector: one registered stage plus a history bit.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_pulse
);

    logic r_cur;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur  <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_cur  <= i_sig;
            r_prev <= r_cur;
        end
    end

    assign o_pulse = r_cur & ~r_prev;

endmodule

// File: rtl/level_progress_ctrl.sv
// Game-progress FSM: counts coins, tracks lives, advances levels through a timed CLEAR hold.
module level_progress_ctrl import game_pkg::*; #(
    parameter int unsigned LIVES_INIT = 3,
    parameter int unsigned CLEAR_HOLD = 50_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    level_progress_ctrl_if.master bus
);

    localparam int unsigned HOLD_W = $clog2(CLEAR_HOLD + 1);

    logic w_start_ev;
    logic w_coin_ev;
    logic w_player_ev;

    state_t              r_state;
    logic [HOLD_W-1:0]   r_hold;
    level_code_t         r_level_code;
    logic [SCORE_W-1:0]  r_score;
    logic [LIVES_W-1:0]  r_lives;
    logic                r_level_start;
    logic                r_game_won;
    logic                r_game_over;

    edge_detect u_start_ed  (.clk(clk), .rst(reset), .i_sig(bus.startGame), .o_pulse(w_start_ev));
    edge_detect u_coin_ed   (.clk(clk), .rst(reset), .i_sig(bus.coinHit),   .o_pulse(w_coin_ev));
    edge_detect u_player_ed (.clk(clk), .rst(reset), .i_sig(bus.playerHit), .o_pulse(w_player_ev));

    // A fatal hit outranks a same-cycle coin; otherwise coin, hit and flag all apply.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_hold        <= '0;
            r_level_code  <= LEVEL_ONE;
            r_score       <= '0;
            r_lives       <= LIVES_W'(LIVES_INIT);
            r_level_start <= 1'b0;
            r_game_won    <= 1'b0;
            r_game_over   <= 1'b0;
        end else begin
            r_level_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_ev) begin
                        r_state       <= PLAY;
                        r_level_code  <= LEVEL_ONE;
                        r_score       <= '0;
                        r_lives       <= LIVES_W'(LIVES_INIT);
                        r_level_start <= 1'b1;
                    end
                end
                PLAY: begin
                    if (w_player_ev && (r_lives == LIVES_W'(1))) begin
                        r_lives     <= '0;
                        r_state     <= LOSE;
                        r_game_over <= 1'b1;
                    end else begin
                        if (w_coin_ev) begin
                            r_score <= score_inc(r_score);
                        end
                        if (w_player_ev) begin
                            r_lives <= r_lives - LIVES_W'(1);
                        end
                        if (bus.flagHit && bus.flagEnable) begin
                            r_state <= CLEAR;
                            r_hold  <= HOLD_W'(CLEAR_HOLD - 1);
                        end
                    end
                end
                CLEAR: begin
                    if (r_hold != '0) begin
                        r_hold <= r_hold - HOLD_W'(1);
                    end else if (r_level_code == LEVEL_ONE) begin
                        r_level_code  <= LEVEL_TWO;
                        r_score       <= '0;
                        r_state       <= PLAY;
                        r_level_start <= 1'b1;
                    end else begin
                        r_level_code <= LEVEL_WON;
                        r_state      <= WIN;
                        r_game_won   <= 1'b1;
                    end
                end
                WIN, LOSE: begin
                    if (w_start_ev) begin
                        r_state      <= IDLE;
                        r_level_code <= LEVEL_ONE;
                        r_score      <= '0;
                        r_lives      <= LIVES_W'(LIVES_INIT);
                        r_game_won   <= 1'b0;
                        r_game_over  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.levelCode  = r_level_code;
    assign bus.score      = r_score;
    assign bus.lives      = r_lives;
    assign bus.levelStart = r_level_start;
    assign bus.gameWon    = r_game_won;
    assign bus.gameOver   = r_game_over;

endmodule

// File: tb/tb_level_progress_ctrl.sv
// Scoreboard bench: stimulus pushes expected output snapshots, a monitor pops one per observed output change.
module tb_level_progress_ctrl;

    logic clk;
    logic reset;
    int   cyc;

    level_progress_ctrl_if bus();

    level_progress_ctrl #(.LIVES_INIT(3), .CLEAR_HOLD(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       rst;
        logic       ls;
        logic [1:0] lc;
        logic [3:0] score;
        logic [2:0] lives;
        logic       won;
        logic       over;
    } snap_t;

    typedef struct {
        snap_t s;
        int    cyc;
        string name;
    } exp_t;

    exp_t q[$];
    int   n_checks;
    int   n_pass;

    // Reference model of the visible outputs
    logic [1:0] m_lc;
    int         m_score;
    int         m_lives;
    logic       m_won;
    logic       m_over;

    function automatic snap_t strip(input snap_t s);
        snap_t r;
        r    = s;
        r.ls = 1'b0;
        return r;
    endfunction

    task automatic push(input string name, input logic rst, input logic ls, input int c);
        exp_t e;
        e.s.rst   = rst;
        e.s.ls    = ls;
        e.s.lc    = m_lc;
        e.s.score = 4'(m_score);
        e.s.lives = 3'(m_lives);
        e.s.won   = m_won;
        e.s.over  = m_over;
        e.cyc     = c;
        e.name    = name;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_lc    = 2'b00;
        m_score = 0;
        m_lives = 3;
        m_won   = 1'b0;
        m_over  = 1'b0;
    endtask

    task automatic start_key(input bit to_play);
        int c;
        c = cyc;
        bus.startGame = 1'b1;
        model_reset();
        if (to_play) push("start_play", 1'b0, 1'b1, c + 2);
        else         push("back_idle",  1'b0, 1'b0, c + 2);
        tick(3);
        bus.startGame = 1'b0;
        tick(2);
    endtask

    task automatic coin(input int hold);
        int c;
        c = cyc;
        bus.coinHit = 1'b1;
        if (m_score < 15) begin
            m_score++;
            push("coin", 1'b0, 1'b0, c + 2);
        end
        tick(hold);
        bus.coinHit = 1'b0;
        tick(2);
    endtask

    task automatic hit(input bit with_coin);
        int c;
        c = cyc;
        bus.playerHit = 1'b1;
        bus.coinHit   = with_coin;
        if (m_lives == 1) begin
            m_lives = 0;
            m_over  = 1'b1;
        end else begin
            m_lives--;
            if (with_coin && m_score < 15) m_score++;
        end
        push(with_coin ? "hit_coin" : "hit", 1'b0, 1'b0, c + 2);
        tick(3);
        bus.playerHit = 1'b0;
        bus.coinHit   = 1'b0;
        tick(2);
    endtask

    // Flag with enable, then collisions during CLEAR that must be ignored
    task automatic flag_clear();
        int c;
        c = cyc;
        bus.flagHit    = 1'b1;
        bus.flagEnable = 1'b1;
        if (m_lc == 2'b00) begin
            m_lc    = 2'b01;
            m_score = 0;
            push("level2", 1'b0, 1'b1, c + 9);
        end else begin
            m_lc  = 2'b10;
            m_won = 1'b1;
            push("won", 1'b0, 1'b0, c + 9);
        end
        tick(2);
        bus.flagHit    = 1'b0;
        bus.flagEnable = 1'b0;
        bus.coinHit    = 1'b1;
        bus.playerHit  = 1'b1;
        tick(2);
        bus.coinHit    = 1'b0;
        bus.playerHit  = 1'b0;
        tick(10);
    endtask

    task automatic do_reset(input int hold);
        reset = 1'b1;
        model_reset();
        push("rst_on", 1'b1, 1'b0, cyc);
        tick(hold);
        reset = 1'b0;
        push("rst_off", 1'b0, 1'b0, cyc);
        tick(2);
    endtask

    // Monitor: every output change (or levelStart pulse) is one transaction
    snap_t cur;
    snap_t prev;
    bit    first;
    int    idle;
    exp_t  e;

    initial begin
        first = 1'b1;
        idle  = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            cur.rst   = reset;
            cur.ls    = bus.levelStart;
            cur.lc    = bus.levelCode;
            cur.score = bus.score;
            cur.lives = bus.lives;
            cur.won   = bus.gameWon;
            cur.over  = bus.gameOver;
            if (first || (strip(cur) != strip(prev)) || cur.ls) begin
                n_checks++;
                idle = 0;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_change @cyc %0d: got rst=%b ls=%b lc=%b score=%0d lives=%0d won=%b over=%b, required no change",
                             cyc, cur.rst, cur.ls, cur.lc, cur.score, cur.lives, cur.won, cur.over);
                end else begin
                    e = q.pop_front();
                    if ((cur === e.s) && ((e.cyc < 0) || (e.cyc == cyc))) begin
                        n_pass++;
                    end else begin
                        $display("FAIL %s: got rst=%b ls=%b lc=%b score=%0d lives=%0d won=%b over=%b cyc=%0d, required rst=%b ls=%b lc=%b score=%0d lives=%0d won=%b over=%b cyc=%0d",
                                 e.name, cur.rst, cur.ls, cur.lc, cur.score, cur.lives, cur.won, cur.over, cyc,
                                 e.s.rst, e.s.ls, e.s.lc, e.s.score, e.s.lives, e.s.won, e.s.over, e.cyc);
                    end
                end
            end else if (q.size() != 0) begin
                idle++;
                if (idle > 100) begin
                    n_checks++;
                    e = q.pop_front();
                    $display("FAIL %s: got no output change within 100 cycles, required change at cyc %0d", e.name, e.cyc);
                    idle = 0;
                end
            end else begin
                idle = 0;
            end
            first = 1'b0;
            prev  = cur;
        end
    end

    initial begin
        int c;
        n_checks       = 0;
        n_pass         = 0;
        reset          = 1'b1;
        bus.startGame  = 1'b0;
        bus.coinHit    = 1'b0;
        bus.flagHit    = 1'b0;
        bus.flagEnable = 1'b0;
        bus.playerHit  = 1'b0;
        model_reset();
        push("reset", 1'b1, 1'b0, -1);
        tick(3);
        reset = 1'b0;
        push("reset_release", 1'b0, 1'b0, cyc);
        tick(2);

        // Level 1: long coin holds count once, flag needs enable, coin+flag same cycle
        start_key(1'b1);
        repeat (3) coin(10);
        bus.flagHit = 1'b1;
        tick(5);
        c = cyc;
        bus.coinHit = 1'b1;
        m_score = 4;
        push("coin_with_flag", 1'b0, 1'b0, c + 2);
        tick(1);
        bus.flagEnable = 1'b1;
        m_lc    = 2'b01;
        m_score = 0;
        push("level2_after_hold", 1'b0, 1'b1, c + 10);
        tick(2);
        bus.flagHit    = 1'b0;
        bus.flagEnable = 1'b0;
        tick(7);
        bus.coinHit = 1'b0;
        tick(4);

        // Level 2 to win, then back to idle
        repeat (6) coin(10);
        flag_clear();
        start_key(1'b0);

        // Lives: plain hit, hit+coin, fatal hit+coin
        start_key(1'b1);
        coin(3);
        hit(1'b0);
        hit(1'b1);
        hit(1'b1);
        start_key(1'b0);

        // Score saturation
        start_key(1'b1);
        repeat (20) coin(2);

        // Reset in the middle of a level-1 CLEAR
        do_reset(2);
        start_key(1'b1);
        repeat (2) coin(3);
        bus.flagHit    = 1'b1;
        bus.flagEnable = 1'b1;
        tick(2);
        bus.flagHit    = 1'b0;
        bus.flagEnable = 1'b0;
        tick(2);
        do_reset(2);
        tick(15);

        tick(5);
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL leftover_expectations: got %0d pending, required 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
